// File: rtl/pc_pkg.sv
// Shared constants, next-PC source encoding and alignment helper for the PC sequencer.
package pc_pkg;

  localparam int                      DEF_WIDTH        = 32;
  localparam int                      DEF_STEP         = 4;
  localparam logic [DEF_WIDTH-1:0]    DEF_RESET_VECTOR = '0;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_HOLD,
    SRC_FAULT,
    SRC_RAS,
    SRC_TARGET,
    SRC_SEQ
  } pc_src_e;

  // Number of low address bits that must be zero for a STEP-aligned target.
  function automatic int align_bits(input int step);
    int b;
    b = 0;
    while ((1 << b) < step) b++;
    return b;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with saturating count; present only when PC_SEQ_RAS_EN is defined.
`ifdef PC_SEQ_RAS_EN
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;

  assign top   = mem[ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push when full lands on the oldest slot, so overflow discards the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr + PW'(1)] <= din;
    end else if (replace) begin
      mem[ptr] <= din;
    end
  end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Fetch program counter with stall, redirect, call/return and sticky misalignment fault.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               STEP         = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             fault,
  output logic             ras_empty
);

  localparam int               ABITS      = align_bits(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'(1) << ABITS) - 64'(1));

  pc_src_e          src;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty_i;
  logic             misaligned;
  logic             advance;

  assign pc_next_seq = pc + WIDTH'(STEP);
  assign ras_empty   = ras_empty_i;

  // A return only consumes target when the stack cannot supply the address.
  assign misaligned = ((target & ALIGN_MASK) != '0) && (redirect || (ret && ras_empty_i));

  always_comb begin
    src = SRC_SEQ;
    if (rst)                    src = SRC_RESET;
    else if (fault)             src = SRC_FAULT;
    else if (stall)             src = SRC_HOLD;
    else if (misaligned)        src = SRC_FAULT;
    else if (ret)               src = ras_empty_i ? SRC_TARGET : SRC_RAS;
    else if (redirect)          src = SRC_TARGET;
  end

  assign advance = (src == SRC_RAS) || (src == SRC_TARGET) || (src == SRC_SEQ);

`ifdef PC_SEQ_RAS_EN
  logic ras_push, ras_pop, ras_replace, ras_full;
  logic unused_full;

  // Tail call swaps the top in place; on an empty stack it degenerates to a push.
  assign ras_push    = advance && redirect && call && (!ret || ras_empty_i);
  assign ras_replace = advance && redirect && call && ret && !ras_empty_i;
  assign ras_pop     = advance && ret && !(redirect && call);
  assign unused_full = ras_full;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .din     (pc_next_seq),
    .top     (ras_top),
    .empty   (ras_empty_i),
    .full    (ras_full)
  );
`else
  logic unused_call;

  assign ras_top     = '0;
  assign ras_empty_i = 1'b1;
  assign unused_call = call ^ advance ^ RAS_DEPTH[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      fault <= 1'b0;
    end else begin
      case (src)
        SRC_RAS:    pc    <= ras_top;
        SRC_TARGET: pc    <= target;
        SRC_SEQ:    pc    <= pc_next_seq;
        SRC_FAULT:  fault <= 1'b1;
        default:    pc    <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; expectations adapt to PC_SEQ_RAS_EN.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] pc, pc_next_seq;
  logic        fault, ras_empty;
  logic [7:0]  pc8, pc8_next;
  logic        fault8, empty8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fault;
    logic        empty;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk (clk), .rst (rst), .stall (stall), .redirect (redirect), .call (call),
    .ret (ret), .target (target), .pc (pc), .pc_next_seq (pc_next_seq),
    .fault (fault), .ras_empty (ras_empty)
  );

  pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'hF8)) dut8 (
    .clk (clk), .rst (rst), .stall (1'b0), .redirect (1'b0), .call (1'b0),
    .ret (1'b0), .target (8'h00), .pc (pc8), .pc_next_seq (pc8_next),
    .fault (fault8), .ras_empty (empty8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rs, input logic s, input logic rd,
                      input logic c, input logic rt, input logic [31:0] t,
                      input logic [31:0] epc, input logic ef, input logic ee);
    exp_t e;
    rst = rs; stall = s; redirect = rd; call = c; ret = rt; target = t;
    sb.push_back('{pc: epc, fault: ef, empty: ee});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".fault"}, {31'b0, fault}, {31'b0, e.fault});
    chk({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, e.empty});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    step("rst",       1, 0, 0, 0, 0, 32'h0,   32'h0,  0, 1);
    chk("rst.pc_next_seq", pc_next_seq, 32'h4);
    chk("rst.pc8", {24'b0, pc8}, 32'hF8);
    chk("rst.fault8", {31'b0, fault8}, 32'h0);
    step("seq1",      0, 0, 0, 0, 0, 32'h0,   32'h4,  0, 1);
    chk("seq1.pc8", {24'b0, pc8}, 32'hFC);
    step("seq2",      0, 0, 0, 0, 0, 32'h0,   32'h8,  0, 1);
    chk("wrap.pc8", {24'b0, pc8}, 32'h00);
    chk("wrap.pc8_next", {24'b0, pc8_next}, 32'h04);
    chk("wrap.empty8", {31'b0, empty8}, 32'h1);
    step("call_only", 0, 0, 0, 1, 0, 32'h0,   32'hC,  0, 1);
    step("seq3",      0, 0, 0, 0, 0, 32'h0,   32'h10, 0, 1);

    step("stall_rd1", 0, 1, 1, 0, 0, 32'h40,  32'h10, 0, 1);
    step("stall_rd2", 0, 1, 1, 0, 0, 32'h40,  32'h10, 0, 1);
    step("rd_go",     0, 0, 1, 0, 0, 32'h40,  32'h40, 0, 1);
    step("stall_mis", 0, 1, 1, 0, 0, 32'h42,  32'h40, 0, 1);

    step("to20",      0, 0, 1, 0, 0, 32'h20,  32'h20, 0, 1);
    step("mis",       0, 0, 1, 0, 0, 32'h42,  32'h20, 1, 1);
    step("frozen_rd", 0, 0, 1, 0, 0, 32'h80,  32'h20, 1, 1);
    step("frozen_sq", 0, 0, 0, 0, 0, 32'h0,   32'h20, 1, 1);
    step("rst_fault", 1, 0, 1, 0, 0, 32'h80,  32'h0,  0, 1);

    step("to100",     0, 0, 1, 0, 0, 32'h100, 32'h100, 0, 1);
    step("call1",     0, 0, 1, 1, 0, 32'h200, 32'h200, 0, !RAS);
    step("seq204",    0, 0, 0, 0, 0, 32'h0,   32'h204, 0, !RAS);
    step("call2",     0, 0, 1, 1, 0, 32'h300, 32'h300, 0, !RAS);
    step("ret1",      0, 0, 0, 0, 1, 32'h900, RAS ? 32'h208 : 32'h900, 0, !RAS);
    step("ret2",      0, 0, 0, 0, 1, 32'hA00, RAS ? 32'h104 : 32'hA00, 0, 1);
    step("ret3",      0, 0, 0, 0, 1, 32'h500, 32'h500, 0, 1);

    step("ovf_c0",    0, 0, 1, 1, 0, 32'h1000, 32'h1000, 0, !RAS);
    step("ovf_c1",    0, 0, 1, 1, 0, 32'h2000, 32'h2000, 0, !RAS);
    step("ovf_c2",    0, 0, 1, 1, 0, 32'h3000, 32'h3000, 0, !RAS);
    step("ovf_c3",    0, 0, 1, 1, 0, 32'h4000, 32'h4000, 0, !RAS);
    step("ovf_c4",    0, 0, 1, 1, 0, 32'h5000, 32'h5000, 0, !RAS);
    step("ovf_r0",    0, 0, 0, 0, 1, 32'h700, RAS ? 32'h4004 : 32'h700, 0, !RAS);
    step("ovf_r1",    0, 0, 0, 0, 1, 32'h710, RAS ? 32'h3004 : 32'h710, 0, !RAS);
    step("ovf_r2",    0, 0, 0, 0, 1, 32'h720, RAS ? 32'h2004 : 32'h720, 0, !RAS);
    step("ovf_r3",    0, 0, 0, 0, 1, 32'h730, RAS ? 32'h1004 : 32'h730, 0, 1);
    step("ovf_r4",    0, 0, 0, 0, 1, 32'h600, 32'h600, 0, 1);

    step("tc_to100",  0, 0, 1, 0, 0, 32'h100, 32'h100, 0, 1);
    step("tc_call",   0, 0, 1, 1, 0, 32'h200, 32'h200, 0, !RAS);
    step("tc_to300",  0, 0, 1, 0, 0, 32'h300, 32'h300, 0, !RAS);
    step("tail",      0, 0, 1, 1, 1, 32'h400, RAS ? 32'h104 : 32'h400, 0, !RAS);
    step("tail_ret",  0, 0, 0, 0, 1, 32'h800, RAS ? 32'h304 : 32'h800, 0, 1);
    step("tail_mt",   0, 0, 1, 1, 1, 32'h900, 32'h900, 0, !RAS);
    step("tail_mt_r", 0, 0, 0, 0, 1, 32'hB00, RAS ? 32'h308 : 32'hB00, 0, 1);

    step("ret_mis",   0, 0, 0, 0, 1, 32'h802, RAS ? 32'h308 : 32'hB00, 1, 1);
    step("rst_stall", 1, 1, 1, 0, 0, 32'h40,  32'h0,  0, 1);
    step("post_rst",  0, 0, 0, 0, 0, 32'h0,   32'h4,  0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter for the single-cycle and pipelined CPU cores. It holds the fetch address and advances it by a fixed step each cycle. It also accepts stall, branch/jump redirect and call/return requests, traps misaligned targets, and can optionally predict return targets with a small return-address stack (RAS). It sits at the head of the fetch path; `pc` drives the instruction memory address.

## Interface
- `WIDTH`, 32: address width in bits.
- `RESET_VECTOR`, 0: value loaded into `pc` on reset.
- `STEP`, 4: sequential increment in bytes; must be a power of two ≥ 1. It also defines the alignment requirement.
- `RAS_DEPTH`, 4: RAS entries, power of two ≥ 2. Used only when `PC_SEQ_RAS_EN` is defined.

- `clk`, in, 1: sole clock; everything updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `stall`, in, 1: hold the current PC.
- `redirect`, in, 1: load `target` (branch or jump taken).
- `call`, in, 1: qualifies `redirect` as a call; push `pc + STEP`.
- `ret`, in, 1: return; next PC comes from the RAS top, or from `target`.
- `target`, in, WIDTH: redirect or return address.
- `pc`, out, WIDTH: current fetch address, registered.
- `pc_next_seq`, out, WIDTH: `pc + STEP`, combinational.
- `fault`, out, 1: sticky misaligned-target flag, registered.
- `ras_empty`, out, 1: RAS holds no entries. Tied to 1 without the macro.

## Operation
- Arithmetic: `pc + STEP` is computed modulo 2^WIDTH. The increment from 2^WIDTH − STEP wraps to 0.
- Misaligned: `target[log2(STEP)-1:0] != 0` while the address is consumed, i.e. on a `redirect`, or on a `ret` that takes its address from `target`.
- Priority per cycle, highest first: `rst`, `fault` held, `stall`, misaligned, `ret`, `redirect`, sequential.
  - `rst`: `pc` ← RESET_VECTOR, `fault` ← 0, RAS count ← 0.
  - `fault` = 1: `pc` frozen and RAS frozen until `rst`.
  - `stall`: `pc` and RAS unchanged. All request inputs are ignored; the requester holds them until `stall` drops.
  - Misaligned: `fault` ← 1, `pc` unchanged, no RAS push or pop.
  - `ret`: `pc` ← RAS top if not empty, otherwise `target`. Pops one entry.
  - `redirect`: `pc` ← `target`. If `call`, also push `pc + STEP`.
  - Sequential: `pc` ← `pc + STEP`.
- `call` without `redirect` is ignored.
- `ret` with `redirect` and `call` in the same cycle is a tail call:
  - next PC = RAS top, or `target` if empty;
  - the top entry is replaced in place by `pc + STEP`; the count is unchanged.
  - If the RAS is empty, the entry is pushed instead (count becomes 1).
- RAS is a circular buffer with a top pointer and a count saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry; the count stays at RAS_DEPTH.
  - Pop when empty leaves the count at 0.

## Timing
- `pc` changes only on the rising edge of `clk`. A request sampled at edge N appears on `pc` after edge N, giving one cycle of redirect latency.
- The value of `pc` before the first `rst` is unspecified; the system must assert `rst` for at least one edge.
- Reset values: `pc` = RESET_VECTOR, `fault` = 0, `ras_empty` = 1. `pc_next_seq` = RESET_VECTOR + STEP, which follows combinationally.
- `fault` asserts the edge after the misaligned request and stays asserted until `rst`.
- `rst` asserted mid-operation, including during stall or fault, takes effect on that edge. Any in-flight request is dropped.
- No combinational path exists from `redirect`, `ret` or `target` to `pc`. `pc_next_seq` depends only on `pc`.

## Configuration
- `PC_SEQ_RAS_EN` defined: RAS instantiated with RAS_DEPTH entries; `ret` uses the stack as described above.
- `PC_SEQ_RAS_EN` undefined: no storage is instantiated and `call` has no effect. `ret` behaves exactly as `redirect` to `target`, including the alignment check, which suits software-managed link registers. `ras_empty` is constant 1.

## Structure
- Shared package `pc_pkg`:
  - default WIDTH, STEP and RESET_VECTOR constants;
  - an `align_bits(STEP)` constant function;
  - an enum of next-PC sources: RESET, HOLD, FAULT, RAS, TARGET, SEQ.
- Sub-module `pc_ras`: push, pop and replace ports plus top, empty and full outputs. It is generated only under `PC_SEQ_RAS_EN`.
- The top level holds the PC register, the priority mux and the fault flag.

## Test plan
- Reset then run: `rst` for 1 cycle, then 3 free-running cycles → `pc` reads 0x0, 0x4, 0x8, 0xC. Start from WIDTH=8, RESET_VECTOR=0xF8 → `pc` reads 0xF8, 0xFC, 0x00.
- Stall versus redirect: at `pc`=0x10, assert `stall` and `redirect` with `target`=0x40 for 2 cycles → `pc` holds 0x10. Drop `stall` → `pc`=0x40 on the next edge.
- Misaligned target: `redirect` with `target`=0x42 at `pc`=0x20 → `fault`=1 and `pc` stays 0x20 across later requests. Assert `rst` → `pc`=0x0 and `fault`=0.
- Call and return (with the macro): call at `pc`=0x100 to 0x200, then call at 0x204 to 0x300 → `ras_empty`=0. `ret` → `pc`=0x208. `ret` → `pc`=0x104, `ras_empty`=1. `ret` with `target`=0x500 → `pc`=0x500.
- RAS overflow: with RAS_DEPTH=4, perform 5 nested calls from PCs A0..A4 → 4 returns yield A4+4, A3+4, A2+4, A1+4. A fifth `ret` uses `target`.
- Tail call (with the macro): stack top 0x104, tail call at `pc`=0x300 with `target`=0x400 → `pc`=0x104 and the top becomes 0x304. Without the macro, the same stimulus → `pc`=0x400 and `ras_empty` stays 1.
